// File: rtl/pc_pkg.sv
// ============================================================================
//  Module      : pc_pkg
//  Description : Shared types and constants for the PC fetch unit: FSM state
//                encoding, the RV32 opcodes that redirect the PC, and the
//                trap cause codes.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package pc_pkg;

  // Sequencer states
  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_EXEC  = 2'd1,
    ST_TRAP  = 2'd2
  } state_t;

  // Opcodes that change control flow
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  // Trap cause codes
  localparam logic [1:0] TRAP_MISALIGN = 2'd0;
  localparam logic [1:0] TRAP_TIMEOUT  = 2'd1;

endpackage

`default_nettype wire

// File: rtl/pc_next_calc.sv
// ============================================================================
//  Module      : pc_next_calc
//  Description : Combinational next-PC selection from the executed opcode and
//                the ALU outputs, plus a misalignment flag for the target.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pc_next_calc
  import pc_pkg::*;
(
  input  logic [6:0]  opcode,
  input  logic [31:0] pc,
  input  logic [31:0] imm,
  input  logic        alu_zero,
  input  logic [31:0] alu_result,
  output logic [31:0] next_pc,
  output logic        misaligned
);

  // JALR ignores bit 0 of the computed target
  logic w_unused_lsb;
  assign w_unused_lsb = alu_result[0];

  // Priority: JALR, JAL, taken branch, sequential. The ALU reports zero=1 for
  // non-branch ops, so alu_zero only matters when the opcode is a branch.
  always_comb begin
    next_pc = pc + 32'd4;
    if (opcode == OP_JALR) begin
      next_pc = {alu_result[31:1], 1'b0};
    end else if (opcode == OP_JAL) begin
      next_pc = pc + imm;
    end else if ((opcode == OP_BRANCH) && alu_zero) begin
      next_pc = pc + imm;
    end
  end

  assign misaligned = |next_pc[1:0];

endmodule

`default_nettype wire

// File: rtl/pc_fetch_unit.sv
// ============================================================================
//  Module      : pc_fetch_unit
//  Description : Program counter and fetch/execute sequencer. Fetches one
//                instruction over a req/ready handshake, holds it for execute,
//                and on exec_done redirects the PC from the ALU outputs.
//                Misaligned targets trap to TRAP_VEC.
//                Optional: define IMEM_TIMEOUT_EN to trap when instruction
//                memory does not respond within TIMEOUT_CYC fetch cycles.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pc_fetch_unit
  import pc_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter logic [31:0] TRAP_VEC    = 32'h0000_0100,
  parameter int          TIMEOUT_CYC = 16
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic [31:0] pc_o,
  output logic [31:0] link_o,
  input  logic [31:0] imm,
  input  logic        alu_zero,
  input  logic [31:0] alu_result,
  input  logic        exec_done,
  output logic        trap_o,
  output logic [1:0]  trap_cause,
  output logic [31:0] trap_epc
);

  state_t      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_instr;
  logic [31:0] r_trap_epc;
  logic [1:0]  r_trap_cause;
  logic        r_req;
  logic        r_valid;
  logic        r_trap;

  logic [31:0] w_next_pc;
  logic        w_misaligned;
  logic        w_timeout;

  pc_next_calc u_next_calc (
    .opcode     (r_instr[6:0]),
    .pc         (r_pc),
    .imm        (imm),
    .alu_zero   (alu_zero),
    .alu_result (alu_result),
    .next_pc    (w_next_pc),
    .misaligned (w_misaligned)
  );

`ifdef IMEM_TIMEOUT_EN
  localparam int c_wait_w = $clog2(TIMEOUT_CYC + 1);

  logic [c_wait_w-1:0] r_wait;

  // Terminal count is the TIMEOUT_CYC-th consecutive cycle without ready;
  // a ready in that same cycle still completes the fetch.
  assign w_timeout = (r_state == ST_FETCH) && !imem_ready &&
                     (r_wait == c_wait_w'(TIMEOUT_CYC - 1));

  // Count unanswered fetch cycles; held at zero outside FETCH so it restarts on entry
  always_ff @(posedge clk) begin
    if (rst || (r_state != ST_FETCH) || imem_ready || w_timeout) begin
      r_wait <= '0;
    end else begin
      r_wait <= r_wait + 1'b1;
    end
  end
`else
  localparam int c_unused_timeout = TIMEOUT_CYC;
  assign w_timeout = 1'b0;
`endif

  // Fetch/execute/trap sequencer with registered handshake and status outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_FETCH;
      r_pc         <= RESET_PC;
      r_instr      <= '0;
      r_trap_cause <= TRAP_MISALIGN;
      r_trap_epc   <= '0;
      r_req        <= 1'b1;
      r_valid      <= 1'b0;
      r_trap       <= 1'b0;
    end else begin
      case (r_state)
        ST_FETCH: begin
          if (imem_ready) begin
            r_instr <= imem_rdata;
            r_state <= ST_EXEC;
            r_req   <= 1'b0;
            r_valid <= 1'b1;
          end else if (w_timeout) begin
            r_state      <= ST_TRAP;
            r_trap_cause <= TRAP_TIMEOUT;
            r_trap_epc   <= r_pc;
            r_req        <= 1'b0;
            r_trap       <= 1'b1;
          end
        end
        ST_EXEC: begin
          if (exec_done) begin
            r_valid <= 1'b0;
            if (w_misaligned) begin
              // PC keeps the faulting instruction's address for trap_epc
              r_state      <= ST_TRAP;
              r_trap_cause <= TRAP_MISALIGN;
              r_trap_epc   <= r_pc;
              r_trap       <= 1'b1;
            end else begin
              r_pc    <= w_next_pc;
              r_state <= ST_FETCH;
              r_req   <= 1'b1;
            end
          end
        end
        ST_TRAP: begin
          r_pc    <= TRAP_VEC;
          r_state <= ST_FETCH;
          r_req   <= 1'b1;
          r_trap  <= 1'b0;
        end
        default: begin
          r_state <= ST_FETCH;
          r_req   <= 1'b1;
          r_valid <= 1'b0;
          r_trap  <= 1'b0;
        end
      endcase
    end
  end

  assign imem_req    = r_req;
  assign imem_addr   = r_pc;
  assign instr       = r_instr;
  assign instr_valid = r_valid;
  assign pc_o        = r_pc;
  assign link_o      = r_pc + 32'd4;
  assign trap_o      = r_trap;
  assign trap_cause  = r_trap_cause;
  assign trap_epc    = r_trap_epc;

endmodule

`default_nettype wire

// File: tb/tb_pc_fetch_unit.sv
// ============================================================================
//  Module      : tb_pc_fetch_unit
//  Description : Self-checking bench for pc_fetch_unit: directed vector table,
//                reset/wait corner sequences, and randomized instructions
//                checked against a next-PC reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pc_fetch_unit;

  localparam logic [31:0] TB_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] TB_TRAP_VEC = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic        instr_valid;
  logic [31:0] pc_o;
  logic [31:0] link_o;
  logic [31:0] imm;
  logic        alu_zero;
  logic [31:0] alu_result;
  logic        exec_done;
  logic        trap_o;
  logic [1:0]  trap_cause;
  logic [31:0] trap_epc;

  int vecs = 0;
  int errs = 0;
  logic [31:0] m_pc;

  always #5 clk = ~clk;

  pc_fetch_unit dut (
    .clk         (clk),
    .rst         (rst),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ready  (imem_ready),
    .imem_rdata  (imem_rdata),
    .instr       (instr),
    .instr_valid (instr_valid),
    .pc_o        (pc_o),
    .link_o      (link_o),
    .imm         (imm),
    .alu_zero    (alu_zero),
    .alu_result  (alu_result),
    .exec_done   (exec_done),
    .trap_o      (trap_o),
    .trap_cause  (trap_cause),
    .trap_epc    (trap_epc)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: next PC from the architectural rules, trap if not word aligned
  function automatic void ref_next(input logic [31:0] pc, input logic [31:0] word,
                                   input logic [31:0] immv, input logic zero,
                                   input logic [31:0] res,
                                   output logic [31:0] nxt, output logic trap);
    logic [6:0] op;
    op = word[6:0];
    if (op == 7'h67)                nxt = res & 32'hFFFF_FFFE;
    else if (op == 7'h6F)           nxt = pc + immv;
    else if (op == 7'h63 && zero)   nxt = pc + immv;
    else                            nxt = pc + 32'd4;
    trap = (nxt % 4) != 0;
  endfunction

  // One full fetch/execute round trip starting in FETCH at m_pc.
  // exp_next is the address of the following fetch (TRAP_VEC after a trap).
  task automatic run_instr(input logic [31:0] word, input logic [31:0] immv,
                           input logic zero, input logic [31:0] res,
                           input logic [31:0] exp_next, input logic exp_trap,
                           input int fetch_wait, input int exec_wait);
    logic [31:0] r;
    for (int i = 0; i < fetch_wait; i++) begin
      imem_ready = 1'b0;
      r = $urandom;
      imem_rdata = r;
      exec_done  = r[3];
      chk("wait_req", imem_req, 1);
      chk("wait_addr", imem_addr, m_pc);
      chk("wait_valid", instr_valid, 0);
      step();
    end
    chk("fetch_req", imem_req, 1);
    chk("fetch_addr", imem_addr, m_pc);
    r = $urandom;
    imem_ready = 1'b1;
    imem_rdata = word;
    exec_done  = r[0];
    step();
    r = $urandom;
    imem_ready = r[0];
    imem_rdata = r;
    exec_done  = 1'b0;
    chk("exec_valid", instr_valid, 1);
    chk("exec_req", imem_req, 0);
    chk("exec_instr", instr, word);
    chk("exec_pc", pc_o, m_pc);
    chk("exec_link", link_o, m_pc + 32'd4);
    for (int i = 0; i < exec_wait; i++) begin
      step();
      chk("exec_hold_valid", instr_valid, 1);
      chk("exec_hold_pc", pc_o, m_pc);
    end
    imm        = immv;
    alu_zero   = zero;
    alu_result = res;
    exec_done  = 1'b1;
    step();
    exec_done  = 1'b0;
    imem_ready = 1'b0;
    if (exp_trap) begin
      chk("trap_pulse", trap_o, 1);
      chk("trap_cause", trap_cause, 0);
      chk("trap_epc", trap_epc, m_pc);
      chk("trap_req", imem_req, 0);
      chk("trap_valid", instr_valid, 0);
      step();
      chk("trap_end", trap_o, 0);
    end else begin
      chk("no_trap", trap_o, 0);
    end
    m_pc = exp_next;
    chk("next_req", imem_req, 1);
    chk("next_addr", imem_addr, m_pc);
    chk("next_valid", instr_valid, 0);
  endtask

  typedef struct {
    logic [31:0] word;
    logic [31:0] immv;
    logic        zero;
    logic [31:0] res;
    logic [31:0] exp_next;
    logic        exp_trap;
  } vec_t;

  vec_t tbl[13];

  initial begin
    // word, imm, zero, alu_result, next fetch, trap
    tbl[0]  = '{32'h0050_0093, 32'h0000_0000, 1'b1, 32'h0000_0005, 32'h0000_0004, 1'b0}; // ADDI @0
    tbl[1]  = '{32'h0000_006F, 32'h0000_001C, 1'b1, 32'h0000_0000, 32'h0000_0020, 1'b0}; // JAL @4
    tbl[2]  = '{32'h0000_0063, 32'h0000_0010, 1'b1, 32'h0000_0000, 32'h0000_0030, 1'b0}; // BEQ taken @20
    tbl[3]  = '{32'h0000_006F, 32'hFFFF_FFF0, 1'b0, 32'h0000_0000, 32'h0000_0020, 1'b0}; // JAL back @30
    tbl[4]  = '{32'h0000_0063, 32'h0000_0010, 1'b0, 32'h0000_0001, 32'h0000_0024, 1'b0}; // BEQ not taken @20
    tbl[5]  = '{32'h0000_0033, 32'h0000_0100, 1'b1, 32'h0000_0000, 32'h0000_0028, 1'b0}; // ADD, zero ignored @24
    tbl[6]  = '{32'h0000_006F, 32'h0000_0018, 1'b0, 32'h0000_0000, 32'h0000_0040, 1'b0}; // JAL @28
    tbl[7]  = '{32'h0000_0067, 32'h0000_0000, 1'b1, 32'h0000_0103, 32'h0000_0100, 1'b1}; // JALR misaligned @40
    tbl[8]  = '{32'h0000_006F, 32'h0000_0002, 1'b1, 32'h0000_0000, 32'h0000_0100, 1'b1}; // JAL misaligned @100
    tbl[9]  = '{32'h0000_0067, 32'h0000_0000, 1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFC, 1'b0}; // JALR to top @100
    tbl[10] = '{32'h0000_0013, 32'h0000_0000, 1'b1, 32'h0000_0000, 32'h0000_0000, 1'b0}; // ADDI wraps @FFFFFFFC
    tbl[11] = '{32'h0000_0063, 32'h0000_0008, 1'b1, 32'h0000_0000, 32'h0000_0008, 1'b0}; // BEQ taken @0
    tbl[12] = '{32'h0000_0067, 32'h0000_0000, 1'b0, 32'h0000_0201, 32'h0000_0200, 1'b0}; // JALR clears bit0 @8
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] r, word, immv, res, nxt;
    logic        zero, tr;
    logic [6:0]  op;

    rst = 1'b1;
    imem_ready = 1'b0;
    imem_rdata = '0;
    imm = '0;
    alu_zero = 1'b0;
    alu_result = '0;
    exec_done = 1'b0;
    step();
    step();
    rst = 1'b0;

    // Reset state
    chk("rst_req", imem_req, 1);
    chk("rst_addr", imem_addr, TB_RESET_PC);
    chk("rst_valid", instr_valid, 0);
    chk("rst_trap", trap_o, 0);
    chk("rst_instr", instr, 0);
    chk("rst_cause", trap_cause, 0);
    chk("rst_epc", trap_epc, 0);
    chk("rst_link", link_o, TB_RESET_PC + 32'd4);
    m_pc = TB_RESET_PC;

    // Directed vectors
    for (int i = 0; i < 13; i++) begin
      run_instr(tbl[i].word, tbl[i].immv, tbl[i].zero, tbl[i].res,
                tbl[i].exp_next, tbl[i].exp_trap, (i == 4) ? 5 : 0, i % 3);
    end
    chk("epc_held", trap_epc, 32'h0000_0100);

    // Reset asserted in the middle of a stalled fetch
    imem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_addr", imem_addr, m_pc);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midrst_addr", imem_addr, TB_RESET_PC);
    chk("midrst_req", imem_req, 1);
    chk("midrst_epc", trap_epc, 0);
    chk("midrst_instr", instr, 0);
    m_pc = TB_RESET_PC;

    // Randomized instruction stream against the reference model
    for (int n = 0; n < 150; n++) begin
      r = $urandom;
      case (r[1:0])
        2'd0: op = 7'h63;
        2'd1: op = 7'h6F;
        2'd2: op = 7'h67;
        default: begin
          op = r[8:2];
          if (op == 7'h63 || op == 7'h6F || op == 7'h67) op = 7'h13;
        end
      endcase
      word = {r[31:7], op};
      immv = $urandom;
      if ($urandom_range(0, 3) != 0) immv[1:0] = 2'b00;
      res  = $urandom;
      zero = r[9];
      ref_next(m_pc, word, immv, zero, res, nxt, tr);
      run_instr(word, immv, zero, res, tr ? TB_TRAP_VEC : nxt, tr,
                $urandom_range(0, 3), $urandom_range(0, 2));
    end

`ifdef IMEM_TIMEOUT_EN
    // Memory never answers: trap with cause 1 after 16 unanswered cycles
    rst = 1'b1;
    step();
    rst = 1'b0;
    imem_ready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      chk("to_req", imem_req, 1);
      chk("to_trap", trap_o, 0);
      step();
    end
    chk("to_pulse", trap_o, 1);
    chk("to_cause", trap_cause, 1);
    chk("to_epc", trap_epc, TB_RESET_PC);
    chk("to_req_drop", imem_req, 0);
    step();
    chk("to_vec", imem_addr, TB_TRAP_VEC);
    chk("to_vec_req", imem_req, 1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

`default_nettype wire
